fetch_sequencer: RTL and testbench

Sequences instruction fetch for the pipelined CPU: owns the architectural PC register, issues requests to instruction memory over a ready handshake, and holds each fetched instruction until the decode stage accepts it. Branch and jump targets computed by the next-PC logic arrive as one-cycle redirects. They are applied with MIPS delay-slot semantics: the instruction already fetched or in flight is kept, and the redirect replaces only the PC that follows it. Sits between the next-PC logic and the IF/ID pipeline register.

---
 rtl/fetch_sequencer_if.sv | 21 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/response bundle
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and fetch sequencer with delay-slot redirects
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  fetch_sequencer_if.master  imem,
  output logic               o_instr_valid,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_pc_out,
  output logic [31:0]        o_pc_plus4,
  output logic [31:0]        o_fetch_count,
  output logic               o_misalign
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_pend;
  logic [31:0] r_tgt;
  logic [31:0] r_count;
  logic        r_misalign;

  logic        w_capture;
  logic        w_accept;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_redirect_tgt = {i_redirect_pc[31:2], 2'b00};
  assign w_pc_plus4     = r_pc + 32'd4;

  // A live redirect beats a buffered one; the buffered one beats sequential flow.
  assign w_next_pc = i_redirect_valid ? w_redirect_tgt :
                     r_pend           ? r_tgt          : w_pc_plus4;

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imem.imem_ready) begin
          w_capture    = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          w_accept     = 1'b1;
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_pend     <= 1'b0;
      r_tgt      <= 32'd0;
      r_count    <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_instr <= imem.imem_rdata;
      end
      if (w_accept) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 32'd1;
        r_pend  <= 1'b0;
      end else if (i_redirect_valid) begin
        // Cannot steer the PC yet; the latest target wins.
        r_pend <= 1'b1;
        r_tgt  <= w_redirect_tgt;
      end
      if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = r_pc;
  assign o_instr_valid  = (r_state == S_HOLD);
  assign o_instr        = r_instr;
  assign o_pc_out       = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_fetch_count  = r_count;
  assign o_misalign     = r_misalign;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table plus accept scoreboard for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_count;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_stall          (stall),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .imem             (bus.master),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_pc_out         (pc_out),
    .o_pc_plus4       (pc_plus4),
    .o_fetch_count    (fetch_count),
    .o_misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = memfn(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of PCs expected to be handed to decode, in order.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_unexpected: got pc %h expected no accept", pc_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("accept_pc", pc_out, e);
        chk("accept_instr", instr, memfn(e));
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic st, input logic v,
                     input logic [31:0] p, input logic er, input logic [31:0] ep,
                     input logic [31:0] ec, input logic em);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.stall = st; t.rv = v; t.rpc = p;
    t.e_req = er; t.e_pc = ep; t.e_cnt = ec; t.e_mis = em;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rdy, input logic st, input logic v, input logic [31:0] p);
    @(posedge clk);
    #1;
    bus.imem_ready = rdy;
    stall          = st;
    rv             = v;
    rpc            = p;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = 32'd0; bus.imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc_out, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_cnt", fetch_count, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);

    //   rst rdy stl rv rpc            req pc             cnt mis
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3000, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3004, 1, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3008, 2, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3008, 2, 0);
    add(1, 0, 0, 0, 32'h0,         1, 32'h0000_300C, 3, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3000, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 0);
    add(0, 0, 0, 1, 32'h0000_3100, 0, 32'h0000_3004, 1, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3100, 2, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3100, 2, 0);
    add(0, 0, 0, 1, 32'h0000_3200, 1, 32'h0000_3104, 3, 0);
    add(0, 0, 1, 0, 32'h0,         1, 32'h0000_3104, 3, 0);
    add(0, 0, 0, 0, 32'h0,         1, 32'h0000_3104, 3, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3104, 3, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3104, 3, 0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3200, 4, 0);
    add(0, 0, 1, 1, 32'h0000_3302, 0, 32'h0000_3200, 4, 0);
    add(0, 0, 1, 0, 32'h0,         0, 32'h0000_3200, 4, 1);
    add(0, 1, 1, 0, 32'h0,         0, 32'h0000_3200, 4, 1);
    add(0, 0, 1, 0, 32'h0,         0, 32'h0000_3200, 4, 1);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3200, 4, 1);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0000_3300, 5, 1);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0000_3300, 5, 1);
    add(0, 0, 0, 0, 32'h0,         1, 32'h0000_3304, 6, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst            = vecs[i].rst;
      bus.imem_ready = vecs[i].rdy;
      stall          = vecs[i].stall;
      rv             = vecs[i].rv;
      rpc            = vecs[i].rpc;
      if (!vecs[i].e_req && !vecs[i].stall && !vecs[i].rst) exp_q.push_back(vecs[i].e_pc);
      @(negedge clk);
      chk($sformatf("row%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("row%0d_valid", i), {31'd0, instr_valid}, {31'd0, ~vecs[i].e_req});
      chk($sformatf("row%0d_pc", i), pc_out, vecs[i].e_pc);
      chk($sformatf("row%0d_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("row%0d_cnt", i), fetch_count, vecs[i].e_cnt);
      chk($sformatf("row%0d_mis", i), {31'd0, misalign}, {31'd0, vecs[i].e_mis});
      if (vecs[i].e_req) chk($sformatf("row%0d_addr", i), bus.imem_addr, vecs[i].e_pc);
      else chk($sformatf("row%0d_instr", i), instr, memfn(vecs[i].e_pc));
    end

    // Two redirects before the delay slot is accepted: the later target wins.
    drive(1, 0, 1, 32'h0000_4000);
    chk("lw_req_addr", bus.imem_addr, 32'h0000_3304);
    drive(0, 1, 1, 32'h0000_5000);
    chk("lw_hold", {31'd0, instr_valid}, 32'd1);
    exp_q.push_back(32'h0000_3304);
    drive(0, 0, 0, 32'h0);
    drive(1, 0, 0, 32'h0);
    chk("lw_target", bus.imem_addr, 32'h0000_5000);
    exp_q.push_back(32'h0000_5000);
    drive(0, 0, 1, 32'hFFFF_FFFC);
    drive(1, 0, 0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'd0);
    exp_q.push_back(32'hFFFF_FFFC);
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    chk("wrap_zero", bus.imem_addr, 32'd0);
    chk("wrap_cnt", fetch_count, 32'd9);
    chk("mis_sticky", {31'd0, misalign}, 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
